// File: rtl/tow_pkg.sv
// Shared types and constants for the tug-of-war game logic.
// Used by the CPU opponent and any other pseudo-random consumers.
package tow_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESS   = 2'd1,
    RELEASE = 2'd2
  } key_state_e;

  // x^10 + x^7 + 1 taken from bits 9 and 6 of a left-shifting register
  localparam logic [9:0] LFSR10_TAPS = 10'b10_0100_0000;
  localparam logic [9:0] LFSR10_SEED = 10'h001;

endpackage

// File: rtl/lfsr_gen.sv
// Fibonacci LFSR that shifts left and inserts the tap parity at bit 0.
// Free-running whenever out of reset.
module lfsr_gen
  import tow_pkg::*;
#(
  parameter int               WIDTH = 10,
  parameter logic [WIDTH-1:0] SEED  = LFSR10_SEED,
  parameter logic [WIDTH-1:0] TAPS  = LFSR10_TAPS
) (
  input  logic             clk,
  input  logic             reset,
  output logic [WIDTH-1:0] q
);

  // An all-zero seed would lock the register up forever
  if (SEED == '0) begin : g_bad_seed
    $error("lfsr_gen: SEED must be nonzero");
  end

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;

  always_comb begin
    q_d = {q_q[WIDTH-2:0], ^(q_q & TAPS)};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q_q <= SEED;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/cpu_key_driver.sv
// Computer opponent: emits an active-low KEY-like waveform whose press
// rate is set by comparing a free-running LFSR against a difficulty value.
module cpu_key_driver
  import tow_pkg::*;
#(
  parameter int                    LFSR_WIDTH     = 10,
  parameter logic [LFSR_WIDTH-1:0] SEED           = LFSR10_SEED,
  parameter int                    PRESS_CYCLES   = 2,
  parameter int                    RELEASE_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [LFSR_WIDTH-1:0] difficulty,
  output logic                  key_n,
  output logic                  press_pulse,
  output logic [LFSR_WIDTH-1:0] lfsr_q
);

  localparam int CNT_MAX = (PRESS_CYCLES > RELEASE_CYCLES) ? PRESS_CYCLES : RELEASE_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] PRESS_LOAD   = CNT_W'(PRESS_CYCLES - 1);
  localparam logic [CNT_W-1:0] RELEASE_LOAD = CNT_W'(RELEASE_CYCLES - 1);

  key_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             key_n_q, key_n_d;
  logic             pulse_q, pulse_d;
  logic             fire;

  lfsr_gen #(
    .WIDTH(LFSR_WIDTH),
    .SEED (SEED)
  ) u_lfsr (
    .clk  (clk),
    .reset(reset),
    .q    (lfsr_q)
  );

  assign fire = enable && (lfsr_q < difficulty);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      key_n_q <= 1'b1;
      pulse_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      key_n_q <= key_n_d;
      pulse_q <= pulse_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (fire) begin
          state_d = PRESS;
          cnt_d   = PRESS_LOAD;
        end
      end
      PRESS: begin
        // Dropping enable aborts the press but still owes the full release gap
        if (!enable || cnt_q == '0) begin
          state_d = RELEASE;
          cnt_d   = RELEASE_LOAD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RELEASE: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so they register on the same edge
  always_comb begin
    key_n_d = (state_d != PRESS);
    pulse_d = (state_q == IDLE) && (state_d == PRESS);
  end

  assign key_n       = key_n_q;
  assign press_pulse = pulse_q;

endmodule

// File: tb/tb_cpu_key_driver.sv
// Bench for cpu_key_driver: a schedule-based reference model feeds a
// scoreboard queue that a separate monitor drains every cycle.
module tb_cpu_key_driver;

  localparam int         P    = 2;
  localparam int         R    = 2;
  localparam logic [9:0] SEED = 10'h001;

  logic       clk;
  logic       rst_n;
  logic       enable;
  logic [9:0] difficulty;
  logic       key_n;
  logic       press_pulse;
  logic [9:0] lfsr_q;

  int n_tests = 0;
  int n_fail  = 0;

  cpu_key_driver #(
    .LFSR_WIDTH    (10),
    .SEED          (SEED),
    .PRESS_CYCLES  (P),
    .RELEASE_CYCLES(R)
  ) dut (
    .clk        (clk),
    .reset      (rst_n),
    .enable     (enable),
    .difficulty (difficulty),
    .key_n      (key_n),
    .press_pulse(press_pulse),
    .lfsr_q     (lfsr_q)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a press is a queued schedule of future key levels
  logic [11:0] exp_q[$];
  bit          sched[$];
  logic [9:0]  m_lfsr = SEED;
  logic        m_key  = 1'b1;
  logic        m_pulse = 1'b0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_lfsr  = SEED;
      m_key   = 1'b1;
      m_pulse = 1'b0;
      sched.delete();
    end else begin
      m_pulse = 1'b0;
      if (sched.size() == 0) begin
        if (enable && (m_lfsr < difficulty)) begin
          for (int i = 0; i < P; i++) sched.push_back(1'b0);
          for (int i = 0; i < R + 1; i++) sched.push_back(1'b1);
          m_pulse = 1'b1;
        end
      end else if (!m_key && !enable) begin
        while (sched.size() > 0 && sched[0] == 1'b0) void'(sched.pop_front());
      end
      m_key  = (sched.size() > 0) ? sched.pop_front() : 1'b1;
      m_lfsr = 10'(((m_lfsr * 2) % 1024) + ((m_lfsr >> 9) ^ ((m_lfsr >> 6) & 10'd1)));
    end
    exp_q.push_back({m_key, m_pulse, m_lfsr});
  end

  // Monitor
  always begin
    logic [11:0] e;
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      chk("sb_underflow", 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      chk("sb_key_n", {31'd0, key_n}, {31'd0, e[11]});
      chk("sb_press_pulse", {31'd0, press_pulse}, {31'd0, e[10]});
      chk("sb_lfsr", {22'd0, lfsr_q}, {22'd0, e[9:0]});
    end
  end

  int  n;
  int  pulses;
  int  falls;
  int  lows;
  bit  zero_seen;
  bit  found;
  logic prev_key;

  initial begin
    rst_n      = 1'b0;
    enable     = 1'b1;
    difficulty = 10'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_key_n", {31'd0, key_n}, 32'd1);
    chk("rst_pulse", {31'd0, press_pulse}, 32'd0);
    chk("rst_lfsr", {22'd0, lfsr_q}, 32'h001);

    // LFSR sequence and period, difficulty 0 keeps the key idle meanwhile
    @(negedge clk) rst_n = 1'b1;
    zero_seen = 1'b0;
    n = 0;
    for (int i = 1; i <= 1100; i++) begin
      @(posedge clk);
      #1;
      n = i;
      if (i <= 3) chk("lfsr_first", {22'd0, lfsr_q}, 32'd1 << i);
      if (lfsr_q == 10'd0) zero_seen = 1'b1;
      if (lfsr_q == 10'h001) break;
    end
    chk("lfsr_period", n, 32'd1023);
    chk("lfsr_no_zero", {31'd0, zero_seen}, 32'd0);

    pulses = 0;
    lows   = 0;
    repeat (3000) begin
      @(posedge clk);
      #1;
      if (press_pulse) pulses++;
      if (!key_n) lows++;
    end
    chk("diff0_pulses", pulses, 32'd0);
    chk("diff0_lows", lows, 32'd0);

    // Maximum difficulty: every falling edge of key_n carries one pulse
    @(negedge clk) difficulty = 10'h3FF;
    pulses   = 0;
    falls    = 0;
    prev_key = key_n;
    repeat (200) begin
      @(posedge clk);
      #1;
      if (press_pulse) pulses++;
      if (prev_key && !key_n) falls++;
      if (press_pulse && !(prev_key && !key_n)) chk("pulse_on_fall", 32'd0, 32'd1);
      prev_key = key_n;
    end
    chk("max_pulse_eq_falls", pulses, falls);
    chk("max_many_presses", {31'd0, (pulses >= 30)}, 32'd1);

    // Abort in the first PRESS cycle
    @(negedge clk) enable = 1'b0;
    repeat (8) @(negedge clk);
    enable = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (press_pulse) begin
        found = 1'b1;
        break;
      end
    end
    chk("abort_pulse_seen", {31'd0, found}, 32'd1);
    @(negedge clk) enable = 1'b0;
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      if (press_pulse) pulses++;
      if (i < 3) chk("abort_key_high", {31'd0, key_n}, 32'd1);
    end
    chk("abort_single_pulse", pulses, 32'd0);

    // Async reset in the middle of a press
    @(negedge clk) enable = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (press_pulse) begin
        found = 1'b1;
        break;
      end
    end
    chk("areset_press_seen", {31'd0, found}, 32'd1);
    chk("areset_key_low_before", {31'd0, key_n}, 32'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("areset_key_n", {31'd0, key_n}, 32'd1);
    chk("areset_pulse", {31'd0, press_pulse}, 32'd0);
    chk("areset_lfsr", {22'd0, lfsr_q}, 32'h001);
    @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("areset_lfsr_restart", {22'd0, lfsr_q}, 32'h002);

    // Randomised traffic
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if ($urandom_range(7) == 0) begin
        case ($urandom_range(3))
          0:       difficulty = 10'd0;
          1:       difficulty = 10'h3FF;
          default: difficulty = 10'($urandom);
        endcase
      end
      if ($urandom_range(15) == 0) enable = ~enable;
      if ($urandom_range(499) == 0) begin
        #2 rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
      end
    end

    repeat (3) @(posedge clk);
    #2;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cpu_key_driver.md
Name: cpu_key_driver

Overview:
- Computer-opponent key generator for the tug-of-war game. It is the driving end of the player key interface.
- Produces an active-low, KEY-like level waveform (press, hold, release) at a pseudo-random rate set by a difficulty value from switches.
- Its key_n output feeds the same press-edge detector used for human KEY inputs, so the CPU player enters the game logic exactly as a human does.

Parameters:
- LFSR_WIDTH, 10, width of the random generator and of the difficulty compare.
- SEED, 10'h001, LFSR reset value. Must be nonzero; zero is illegal and is flagged by an elaboration-time assertion.
- PRESS_CYCLES, 2, number of cycles key_n is held low per press (≥1).
- RELEASE_CYCLES, 2, minimum number of cycles key_n is held high after a press (≥1).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset: asserted when 0, deasserted when 1.
- enable  in  1  game running; no new press starts while this is 0.
- difficulty  in  LFSR_WIDTH  press threshold, unsigned; larger means more frequent presses.
- key_n  out  1  simulated key level, active-low (1 = released).
- press_pulse  out  1  one-cycle strobe, high in the first cycle key_n is low.
- lfsr_q  out  LFSR_WIDTH  current LFSR state, for debug and verification.

Behaviour:
- Reset (reset==0, asynchronous):
  - state=IDLE, lfsr_q=SEED, counter=0.
  - key_n=1, press_pulse=0.
  - All outputs are registered, so there are no glitches.
- LFSR:
  - Fibonacci, polynomial x^10+x^7+1; feedback fb = q[9]^q[6]; next q = {q[8:0], fb}.
  - Advances every cycle while out of reset, independent of enable and state.
  - Period is 1023; all-zero is never reached.
- Counter: width is clog2(max(PRESS_CYCLES, RELEASE_CYCLES)) bits.
- FSM states: IDLE, PRESS, RELEASE.
  - IDLE (key_n=1): if enable && (lfsr_q < difficulty), sampled at the clock edge, go to PRESS and load counter=PRESS_CYCLES-1. Otherwise stay in IDLE.
  - PRESS (key_n=0):
    - if enable==0, go to RELEASE immediately and load counter=RELEASE_CYCLES-1;
    - else if counter==0, go to RELEASE and load counter=RELEASE_CYCLES-1;
    - else decrement counter.
  - RELEASE (key_n=1): if counter==0, go to IDLE; else decrement. This state ignores enable.
- Timing and outputs:
  - Decision-to-output latency is 1 cycle. key_n falls in the cycle after the IDLE edge where the compare passes.
  - press_pulse=1 only in that first PRESS cycle. Exactly one pulse per press, even if the press is aborted.
  - A full press keeps key_n low for exactly PRESS_CYCLES cycles. After any press, key_n stays high for at least RELEASE_CYCLES+1 cycles (RELEASE plus at least one IDLE cycle).
  - Minimum press period is PRESS_CYCLES+RELEASE_CYCLES+1 cycles.
- Boundaries:
  - difficulty=0: the compare never passes, so no press ever occurs.
  - difficulty = all ones: a press starts whenever IDLE and lfsr_q ≠ all-ones.
  - difficulty changes mid-press affect only the next IDLE decision.
  - Reset mid-PRESS: key_n returns to 1 asynchronously and press_pulse clears.
  - enable rising: the first possible key_n fall is 1 cycle later.

Decomposition:
- Shared package tow_pkg holds:
  - the state typedef (enum logic [1:0] {IDLE, PRESS, RELEASE});
  - the constant LFSR10_TAPS (bits 9 and 6);
  - the default seed constant.
- One sub-module, lfsr_gen: parameters WIDTH and SEED; ports clk, reset (active-low async), q. It is reused later by other random consumers.
- FSM, counter and compare live in cpu_key_driver.

Test Plan:
- Reset: hold reset=0 with enable=1 → key_n=1, press_pulse=0, lfsr_q=0x001. After release, next values are 0x002, 0x004, 0x008.
- LFSR period: run 1023 cycles from reset → lfsr_q returns to 0x001 for the first time at cycle 1023 and is never 0x000.
- difficulty=0, enable=1 for 3000 cycles → key_n constantly 1, press_pulse never asserts.
- difficulty=10'h3FF, enable=1 → key_n pattern 0,0,1,1,1 repeating (low 2, high ≥3). press_pulse coincides with every key_n falling edge. Each press is detected exactly once when key_n drives the existing press detector.
- Abort: enable drops in the first PRESS cycle → key_n=1 in the next cycle, held high ≥3 cycles, and exactly one press_pulse in total.
- Async reset asserted mid-PRESS (between clock edges) → key_n=1 immediately with no wait for clk. After release, the LFSR restarts from 0x001.
